ansi_key_decoder: RTL and testbench

- Streaming successor to the fixed 4-byte command decoder: consumes terminal bytes one at a time, oldest first, instead of a latched 4-byte snapshot.
- Decodes ANSI/VT100 escape sequences and control bytes into one-cycle command pulses.
- Forwards printable characters unchanged.
- Sits between the UART byte receiver and the line-editor/cursor logic.

---
 rtl/ansi_key_decoder.sv | 238 +++++++++++++++++++++++
 tb/tb_ansi_key_decoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ansi_key_decoder.sv
// Streaming ANSI/VT100 key decoder: turns UART bytes into command pulses and forwards printable characters.
// Optional SS3 (ESC O x) cursor-key support is enabled by defining ANSI_SS3_EN.
module ansi_key_decoder #(
    parameter int PARAM_DIGITS = 2,
    parameter int ESC_TIMEOUT  = 1000,
    parameter int CNT_W        = $clog2(ESC_TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       cmd_valid,
    output logic [3:0] cmd_code,
    output logic       char_valid,
    output logic [7:0] char_data,
    output logic       seq_error
);

    // state | meaning
    // IDLE  | plain text; control bytes and printable characters
    // ESC   | 0x1B seen, waiting for '[' (or 'O' when SS3 is enabled)
    // CSI   | ESC [ seen, waiting for final letter or first digit
    // PARAM | collecting decimal parameter, waiting for '~' or final letter
    // SS3   | ESC O seen, waiting for final letter (ANSI_SS3_EN only)
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ESC   = 3'd1;
    localparam logic [2:0] S_CSI   = 3'd2;
    localparam logic [2:0] S_PARAM = 3'd3;
`ifdef ANSI_SS3_EN
    localparam logic [2:0] S_SS3   = 3'd4;
`endif

    localparam logic [3:0] C_UP     = 4'd1;
    localparam logic [3:0] C_DOWN   = 4'd2;
    localparam logic [3:0] C_RIGHT  = 4'd3;
    localparam logic [3:0] C_LEFT   = 4'd4;
    localparam logic [3:0] C_HOME   = 4'd5;
    localparam logic [3:0] C_END    = 4'd6;
    localparam logic [3:0] C_DELETE = 4'd7;
    localparam logic [3:0] C_ENTER  = 4'd8;
    localparam logic [3:0] C_BS     = 4'd9;
    localparam logic [3:0] C_INSERT = 4'd10;
    localparam logic [3:0] C_PGUP   = 4'd11;
    localparam logic [3:0] C_PGDN   = 4'd12;
    localparam logic [3:0] C_ESC    = 4'd13;

    localparam int PW = $clog2(10 ** PARAM_DIGITS);
    localparam int DW = $clog2(PARAM_DIGITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ESC_TIMEOUT - 1);
    localparam logic [PW+3:0]    TEN      = (PW + 4)'(10);
    localparam logic [DW-1:0]    DIG_MAX  = DW'(PARAM_DIGITS);

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [PW-1:0]    param, param_nxt;
    logic [DW-1:0]    dig_cnt, dig_nxt;
    logic             cr_flag, cr_nxt;

    logic             p_cmd, p_char, p_err;
    logic [3:0]       p_code;
    logic [3:0]       nav;
    logic             is_digit;

    // Final letters shared by CSI, PARAM and SS3; zero means "not a cursor letter".
    function automatic logic [3:0] nav_code(input logic [7:0] b);
        logic [3:0] c;
        case (b)
            8'h41:   c = C_UP;
            8'h42:   c = C_DOWN;
            8'h43:   c = C_RIGHT;
            8'h44:   c = C_LEFT;
            8'h48:   c = C_HOME;
            8'h46:   c = C_END;
            default: c = 4'd0;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] tilde_code(input logic [PW-1:0] p);
        logic [3:0] c;
        c = 4'd0;
        if (p == PW'(1)) c = C_HOME;
        if (p == PW'(2)) c = C_INSERT;
        if (p == PW'(3)) c = C_DELETE;
        if (p == PW'(4)) c = C_END;
        if (p == PW'(5)) c = C_PGUP;
        if (p == PW'(6)) c = C_PGDN;
        return c;
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        param_nxt = param;
        dig_nxt   = dig_cnt;
        cr_nxt    = cr_flag;
        p_cmd     = 1'b0;
        p_code    = 4'd0;
        p_char    = 1'b0;
        p_err     = 1'b0;
        nav       = nav_code(byte_data);
        is_digit  = (byte_data >= 8'h30) && (byte_data <= 8'h39);

        if (byte_valid) begin
            if (byte_data != 8'h0D) cr_nxt = 1'b0;
            case (state)
                S_IDLE: begin
                    if (byte_data == 8'h1B) begin
                        state_nxt = S_ESC;
                    end else if (byte_data == 8'h0D) begin
                        p_cmd  = 1'b1;
                        p_code = C_ENTER;
                        cr_nxt = 1'b1;
                    end else if (byte_data == 8'h0A) begin
                        // LF right after CR belongs to the same line ending
                        if (!cr_flag) begin
                            p_cmd  = 1'b1;
                            p_code = C_ENTER;
                        end
                    end else if (byte_data == 8'h08 || byte_data == 8'h7F) begin
                        p_cmd  = 1'b1;
                        p_code = C_BS;
                    end else if (byte_data >= 8'h20 && byte_data <= 8'h7E) begin
                        p_char = 1'b1;
                    end
                end
                S_ESC: begin
                    if (byte_data == 8'h5B) begin
                        state_nxt = S_CSI;
                    end else if (byte_data == 8'h1B) begin
                        p_cmd  = 1'b1;
                        p_code = C_ESC;
`ifdef ANSI_SS3_EN
                    end else if (byte_data == 8'h4F) begin
                        state_nxt = S_SS3;
`endif
                    end else begin
                        p_err     = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                S_CSI: begin
                    if (nav != 4'd0) begin
                        p_cmd     = 1'b1;
                        p_code    = nav;
                        state_nxt = S_IDLE;
                    end else if (is_digit) begin
                        param_nxt = PW'(byte_data[3:0]);
                        dig_nxt   = DW'(1);
                        state_nxt = S_PARAM;
                    end else begin
                        p_err     = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                S_PARAM: begin
                    if (is_digit) begin
                        if (dig_cnt == DIG_MAX) begin
                            p_err     = 1'b1;
                            state_nxt = S_IDLE;
                        end else begin
                            param_nxt = PW'({4'd0, param} * TEN + (PW + 4)'(byte_data[3:0]));
                            dig_nxt   = dig_cnt + DW'(1);
                        end
                    end else if (byte_data == 8'h7E) begin
                        state_nxt = S_IDLE;
                        if (tilde_code(param) != 4'd0) begin
                            p_cmd  = 1'b1;
                            p_code = tilde_code(param);
                        end else begin
                            p_err = 1'b1;
                        end
                    end else if (nav != 4'd0) begin
                        p_cmd     = 1'b1;
                        p_code    = nav;
                        state_nxt = S_IDLE;
                    end else begin
                        p_err     = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
`ifdef ANSI_SS3_EN
                S_SS3: begin
                    state_nxt = S_IDLE;
                    if (nav != 4'd0) begin
                        p_cmd  = 1'b1;
                        p_code = nav;
                    end else begin
                        p_err = 1'b1;
                    end
                end
`endif
                default: state_nxt = S_IDLE;
            endcase
        end else if (state != S_IDLE) begin
            // A lone ESC that never continues is the ESC key itself
            if (cnt == CNT_LAST) begin
                state_nxt = S_IDLE;
                if (state == S_ESC) begin
                    p_cmd  = 1'b1;
                    p_code = C_ESC;
                end else begin
                    p_err = 1'b1;
                end
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            param      <= '0;
            dig_cnt    <= '0;
            cr_flag    <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_code   <= 4'd0;
            char_valid <= 1'b0;
            char_data  <= 8'd0;
            seq_error  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            param      <= param_nxt;
            dig_cnt    <= dig_nxt;
            cr_flag    <= cr_nxt;
            cmd_valid  <= p_cmd;
            char_valid <= p_char;
            seq_error  <= p_err;
            if (p_cmd)  cmd_code  <= p_code;
            if (p_char) char_data <= byte_data;
        end
    end

endmodule

// File: tb/tb_ansi_key_decoder.sv
// Directed-vector bench for ansi_key_decoder (PARAM_DIGITS=2, ESC_TIMEOUT=20).
module tb_ansi_key_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       cmd_valid;
    logic [3:0] cmd_code;
    logic       char_valid;
    logic [7:0] char_data;
    logic       seq_error;

    int n_vec = 0;
    int n_err = 0;

    ansi_key_decoder #(.PARAM_DIGITS(2), .ESC_TIMEOUT(20)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .char_valid (char_valid),
        .char_data  (char_data),
        .seq_error  (seq_error)
    );

    always #5 clk = ~clk;

    // {cmd_valid, code, char_valid, data, seq_error}; payload fields only count while their strobe is high
    logic [14:0] seen;
    assign seen = {cmd_valid, cmd_valid ? cmd_code : 4'h0,
                   char_valid, char_valid ? char_data : 8'h00, seq_error};

    localparam logic [14:0] NONE = 15'h0000;
    localparam logic [14:0] ERR  = 15'h0001;

    function automatic logic [14:0] e_cmd(input logic [3:0] c);
        return {1'b1, c, 1'b0, 8'h00, 1'b0};
    endfunction

    function automatic logic [14:0] e_chr(input logic [7:0] d);
        return {1'b0, 4'h0, 1'b1, d, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic [14:0] exp, input string tag);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        chk(tag, seen, exp);
    endtask

    task automatic tick(input logic [14:0] exp, input string tag);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk(tag, seen, exp);
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) tick(NONE, "quiet");
    endtask

    initial begin
        rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", seen, NONE);
        @(negedge clk);
        rst_n = 1'b1;
        quiet(1);

        // ESC [ D with 5-cycle spacing
        send(8'h1B, NONE, "left_esc");  quiet(4);
        send(8'h5B, NONE, "left_brk");  quiet(4);
        send(8'h44, e_cmd(4'd4), "left");
        quiet(2);

        // tilde parameters
        send(8'h1B, NONE, "del_esc"); send(8'h5B, NONE, "del_brk"); send(8'h33, NONE, "del_dig");
        send(8'h7E, e_cmd(4'd7), "delete");
        send(8'h1B, NONE, "bad9_esc"); send(8'h5B, NONE, "bad9_brk"); send(8'h39, NONE, "bad9_dig");
        send(8'h7E, ERR, "tilde9_err");
        send(8'h41, e_chr(8'h41), "char_after_err");
        send(8'h1B, NONE, "ins_esc"); send(8'h5B, NONE, "ins_brk"); send(8'h32, NONE, "ins_dig");
        send(8'h7E, e_cmd(4'd10), "insert");
        send(8'h1B, NONE, "pgdn_esc"); send(8'h5B, NONE, "pgdn_brk"); send(8'h36, NONE, "pgdn_dig");
        send(8'h7E, e_cmd(4'd12), "pgdn");
        send(8'h1B, NONE, "p15_esc"); send(8'h5B, NONE, "p15_brk");
        send(8'h31, NONE, "p15_d1"); send(8'h35, NONE, "p15_d2");
        send(8'h41, e_cmd(4'd1), "param_up");

        // line endings and backspace
        send(8'h0D, e_cmd(4'd8), "cr_enter");
        send(8'h0A, NONE, "crlf_collapse");
        send(8'h0A, e_cmd(4'd8), "lf_enter");
        send(8'h7F, e_cmd(4'd9), "backspace");
        send(8'h01, NONE, "ignored_ctl");

        // lone ESC times out into the ESC command
        send(8'h1B, NONE, "to_esc");
        quiet(19);
        tick(e_cmd(4'd13), "esc_timeout");
        quiet(1);
        send(8'h1B, NONE, "csi_to_esc"); send(8'h5B, NONE, "csi_to_brk");
        quiet(19);
        tick(ERR, "csi_timeout");
        // byte on the expiry cycle cancels the timeout
        send(8'h1B, NONE, "cancel_esc");
        quiet(19);
        send(8'h5B, NONE, "cancel_brk");
        quiet(1);
        send(8'h41, e_cmd(4'd1), "cancel_up");

        // ESC ESC, bad follower, bad CSI final
        send(8'h1B, NONE, "ee_esc");
        send(8'h1B, e_cmd(4'd13), "esc_esc");
        send(8'h5B, NONE, "ee_brk");
        send(8'h43, e_cmd(4'd3), "ee_right");
        send(8'h1B, NONE, "bx_esc");
        send(8'h78, ERR, "esc_other_err");
        send(8'h1B, NONE, "bz_esc"); send(8'h5B, NONE, "bz_brk");
        send(8'h5A, ERR, "csi_other_err");

        // digit limit
        send(8'h1B, NONE, "dl_esc"); send(8'h5B, NONE, "dl_brk");
        send(8'h31, NONE, "dl_d1"); send(8'h32, NONE, "dl_d2");
        send(8'h33, ERR, "digit_overflow");

        // reset mid-sequence
        send(8'h1B, NONE, "rm_esc"); send(8'h5B, NONE, "rm_brk");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_mid", seen, NONE);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h41, e_chr(8'h41), "post_reset_char");
        quiet(1);

        // SS3 cursor key
        send(8'h1B, NONE, "ss3_esc");
`ifdef ANSI_SS3_EN
        send(8'h4F, NONE, "ss3_O");
        send(8'h43, e_cmd(4'd3), "ss3_right");
`else
        send(8'h4F, ERR, "ss3_off_err");
        send(8'h43, e_chr(8'h43), "ss3_off_char");
`endif
        quiet(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
